// File: rtl/data_mem_responder.sv
// Multi-cycle word memory for the CPU data port with a programmable-latency mem_ready pulse.
// Faulted requests (misaligned, out of range, read+write) complete with mem_err and touch no storage.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_adr,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        mem_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam int          CW    = $clog2(LATENCY) + 1;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_adr;
  logic [31:0]     r_dat;
  logic            r_rd;
  logic            r_wr;
  logic [31:0]     r_data_out;
  logic            r_ready;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH];

  logic            w_req;
  logic            w_idle;
  logic            w_fin;
  logic [31:0]     w_adr;
  logic [31:0]     w_dat;
  logic            w_rd;
  logic            w_wr;
  logic            w_fault;
  logic [AW-1:0]   w_idx;
  logic            w_mem_we;

  assign w_req  = mem_read | mem_write;
  assign w_idle = (r_state == S_IDLE);

  // With LATENCY=1 the access happens on the accepting edge, so use live inputs there.
  assign w_fin = (w_idle && w_req && (LATENCY == 1)) ||
                 ((r_state == S_WAIT) && (r_cnt == CW'(1)));
  assign w_adr = w_idle ? data_adr  : r_adr;
  assign w_dat = w_idle ? data_in   : r_dat;
  assign w_rd  = w_idle ? mem_read  : r_rd;
  assign w_wr  = w_idle ? mem_write : r_wr;

  assign w_fault  = (w_adr[1:0] != 2'b00) || (w_adr >= LIMIT) || (w_rd && w_wr);
  assign w_idx    = w_adr[AW+1:2];
  assign w_mem_we = w_fin && w_wr && !w_fault && rst;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_data_out <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_adr   <= data_adr;
            r_dat   <= data_in;
            r_rd    <= mem_read;
            r_wr    <= mem_write;
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_fin) begin
        r_ready <= 1'b1;
        r_err   <= w_fault;
        if (w_rd) r_data_out <= w_fault ? 32'h0 : r_mem[w_idx];
      end
    end
  end

  assign data_out  = r_data_out;
  assign mem_ready = r_ready;
  assign mem_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (LATENCY 2, 1, 4) sharing clock and reset.
// Instance 0 carries the main scenarios; 1 and 2 cover the latency corner cases.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] adr  [3];
  logic [31:0] din  [3];
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        err  [3];

  int n_vec;
  int n_err;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .data_adr(adr[0]), .data_in(din[0]),
    .mem_read(rd[0]), .mem_write(wr[0]),
    .data_out(dout[0]), .mem_ready(rdy[0]), .mem_err(err[0])
  );
  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .data_adr(adr[1]), .data_in(din[1]),
    .mem_read(rd[1]), .mem_write(wr[1]),
    .data_out(dout[1]), .mem_ready(rdy[1]), .mem_err(err[1])
  );
  data_mem_responder #(.DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .data_adr(adr[2]), .data_in(din[2]),
    .mem_read(rd[2]), .mem_write(wr[2]),
    .data_out(dout[2]), .mem_ready(rdy[2]), .mem_err(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise a request, hold it until mem_ready, drop it, then confirm the pulse lasted one cycle.
  task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] dt,
                        input logic r, input logic w, input bit swap, input logic [31:0] a_alt,
                        input int exp_cyc, input logic exp_err,
                        input bit chk_dout, input logic [31:0] exp_dout, input string tag);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 0;
    @(negedge clk);
    adr[d] = a; din[d] = dt; rd[d] = r; wr[d] = w;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (swap && i == 1) begin
        adr[d] = a_alt;
        din[d] = ~dt;
      end
      if (rdy[d]) begin
        cyc  = i;
        seen = 1;
        break;
      end
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    chk({tag, "_lat"}, cyc, exp_cyc);
    if (seen) begin
      chk({tag, "_err"}, err[d], exp_err);
      if (chk_dout) chk({tag, "_dout"}, dout[d], exp_dout);
    end
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {err[d], rdy[d]}, 2'b00);
  endtask

  initial begin
    bit bad;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      adr[k] = '0; din[k] = '0; rd[k] = 1'b0; wr[k] = 1'b0;
    end
    #3;
    chk("rst_dout", dout[0], 32'h0);
    chk("rst_rdy",  rdy[0],  1'b0);
    chk("rst_err",  err[0],  1'b0);
    #9 rst = 1'b1;

    // basic write/read, LATENCY=2
    do_req(0, 32'h10, 32'hDEADBEEF, 0, 1, 0, 0, 2, 0, 0, 0, "wr10");
    do_req(0, 32'h10, 32'h0,        1, 0, 0, 0, 2, 0, 1, 32'hDEADBEEF, "rd10");

    // back-to-back
    do_req(0, 32'h0, 32'h1, 0, 1, 0, 0, 2, 0, 0, 0, "wr0");
    do_req(0, 32'h4, 32'h2, 0, 1, 0, 0, 2, 0, 0, 0, "wr4");
    do_req(0, 32'h4, 32'h0, 1, 0, 0, 0, 2, 0, 1, 32'h2, "rd4");
    do_req(0, 32'h0, 32'h0, 1, 0, 0, 0, 2, 0, 1, 32'h1, "rd0");

    // faults and the top in-range word
    do_req(0, 32'h13,  32'h0,  1, 0, 0, 0, 2, 1, 1, 32'h0, "rd_mis");
    do_req(0, 32'h400, 32'h99, 0, 1, 0, 0, 2, 1, 0, 0, "wr_oor");
    do_req(0, 32'h400, 32'h0,  1, 0, 0, 0, 2, 1, 1, 32'h0, "rd_oor");
    do_req(0, 32'h3FC, 32'hCAFE, 0, 1, 0, 0, 2, 0, 0, 0, "wr3fc");
    do_req(0, 32'h3FC, 32'h0,  1, 0, 0, 0, 2, 0, 1, 32'hCAFE, "rd3fc");
    do_req(0, 32'h0,   32'h0,  1, 0, 0, 0, 2, 0, 1, 32'h1, "rd0_again");
    do_req(0, 32'h4,   32'h0,  1, 0, 0, 0, 2, 0, 1, 32'h2, "rd4_again");
    do_req(0, 32'h10,  32'h0,  1, 0, 0, 0, 2, 0, 1, 32'hDEADBEEF, "rd10_again");

    // read and write together
    do_req(0, 32'h20, 32'h55, 0, 1, 0, 0, 2, 0, 0, 0, "wr20");
    do_req(0, 32'h20, 32'hFF, 1, 1, 0, 0, 2, 1, 0, 0, "rdwr20");
    do_req(0, 32'h20, 32'h0,  1, 0, 0, 0, 2, 0, 1, 32'h55, "rd20");

    // reset in the middle of a write
    do_req(0, 32'h8, 32'h12345678, 0, 1, 0, 0, 2, 0, 0, 0, "wr8");
    @(negedge clk);
    adr[0] = 32'h8; din[0] = 32'hAAAA0000; wr[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_pre_rdy", rdy[0], 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_dout", dout[0], 32'h0);
    chk("midrst_rdy",  rdy[0],  1'b0);
    chk("midrst_err",  err[0],  1'b0);
    wr[0] = 1'b0;
    #2 rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (rdy[0]) bad = 1;
    end
    chk("midrst_noready", bad, 1'b0);
    do_req(0, 32'h8, 32'h0, 1, 0, 0, 0, 2, 0, 1, 32'h12345678, "rd8");

    // LATENCY=1
    do_req(1, 32'h4, 32'h77, 0, 1, 0, 0, 1, 0, 0, 0, "l1_wr4");
    do_req(1, 32'h4, 32'h0,  1, 0, 0, 0, 1, 0, 1, 32'h77, "l1_rd4");
    do_req(1, 32'h6, 32'h0,  1, 0, 0, 0, 1, 1, 1, 32'h0, "l1_mis");

    // LATENCY=4 with inputs changing after acceptance
    do_req(2, 32'h8, 32'h11, 0, 1, 0, 0, 4, 0, 0, 0, "l4_wr8");
    do_req(2, 32'hC, 32'h22, 0, 1, 0, 0, 4, 0, 0, 0, "l4_wrc");
    do_req(2, 32'h8, 32'h0,  1, 0, 1, 32'hC, 4, 0, 1, 32'h11, "l4_rd_swap");
    do_req(2, 32'hC, 32'h33, 0, 1, 1, 32'h8, 4, 0, 0, 0, "l4_wr_swap");
    do_req(2, 32'hC, 32'h0,  1, 0, 0, 0, 4, 0, 1, 32'h33, "l4_rdc");
    do_req(2, 32'h8, 32'h0,  1, 0, 0, 0, 4, 0, 1, 32'h11, "l4_rd8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
